multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Execute-stage iterative signed multiply/divide sequencer.
- Consumes operands and the mult/div control decoded from the D/X latch outputs.
- Asserts busy so hazard logic freezes the PC, F/D and D/X latches, and releases a result toward the X/M latch.
- Lets the ALU stay single-cycle while mul/div take WIDTH+1 cycles.

Parameters:
- WIDTH, 32, operand and result width in bits. Counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- ctrl_MULT  input  1  start a signed multiply; sampled only in IDLE.
- ctrl_DIV  input  1  start a signed divide; sampled only in IDLE.
- data_operandA  input  WIDTH  multiplicand / dividend; captured in the start cycle.
- data_operandB  input  WIDTH  multiplier / divisor; captured in the start cycle.
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient (truncated toward zero).
- data_exception  output  1  overflow or divide-by-zero; valid when data_resultRDY=1.
- data_resultRDY  output  1  one-cycle pulse; result and exception valid.
- busy  output  1  high while an operation is in flight (states MULT, DIV).

Behaviour:
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts it. No resultRDY is produced, and operands are discarded.
- States and transitions:
  - IDLE: ctrl_MULT=1 -> MULT; else ctrl_DIV=1 -> DIV. Both high: MULT wins, DIV is dropped. Operands are latched internally on the start edge.
  - MULT: radix-2 Booth, one step per cycle on a 2*WIDTH+1 product/multiplier register. The counter increments each cycle. After WIDTH steps -> DONE.
  - DIV: restoring division on magnitudes |A|, |B|, one quotient bit per cycle, WIDTH steps -> DONE. Quotient sign = signA XOR signB. The remainder is discarded.
  - DONE: data_resultRDY=1 for exactly this cycle, then -> IDLE. A start input seen in DONE is ignored.
- Latency: start sampled at edge k -> busy high in cycles k+1..k+WIDTH -> resultRDY high in cycle k+WIDTH+1 (WIDTH=32: 33 cycles).
- busy is registered. The external stall is formed as busy | ctrl_MULT | ctrl_DIV, outside this block.
- data_result and data_exception hold their value after DONE until the next DONE or reset.
- ctrl_MULT/ctrl_DIV asserted while busy: ignored. Hazard logic guarantees they are held, and they re-trigger only once IDLE is reached.
- Multiply overflow: exception=1 when the 2*WIDTH product is not the sign extension of its low WIDTH bits. data_result still carries the low WIDTH bits.
- Divide-by-zero (B=0): exception=1, result=0.
- Divide overflow (A=-2^(WIDTH-1), B=-1): exception=1, result=0x80000000 (WIDTH=32).
- Back-to-back: a start in the cycle after DONE (the IDLE cycle) is accepted. The minimum issue interval is WIDTH+2 cycles.

Optional Feature:
- Macro MULTDIV_EARLY_OUT_EN.
- Defined: in IDLE, if the started op has operandA=0 or operandB=0, the block skips to DONE.
  - resultRDY is high in cycle k+1 and busy is never asserted.
  - Result is 0. Exception = 1 only for divide with B=0.
- Undefined: zero operands take the full WIDTH+1 latency, with identical result and exception values.

Test Plan:
- MULT A=7, B=-3 -> resultRDY exactly 33 cycles after start; result=0xFFFFFFEB; exception=0; busy high for 32 cycles.
- MULT A=0x40000000, B=4 -> result=0x00000000, exception=1. Then MULT A=-1, B=-1 -> result=1, exception=0.
- DIV A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. DIV A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- DIV A=100, B=0 -> exception=1, result=0. resultRDY at cycle k+33 without the macro, at k+1 with MULTDIV_EARLY_OUT_EN (busy stays 0).
- ctrl_MULT and ctrl_DIV both high with A=6, B=3 -> result=18 (multiply). ctrl_DIV pulsed while busy -> ignored; exactly one resultRDY.
- Reset asserted 10 cycles into a DIV -> next edge: busy=0, result=0, no resultRDY. A new MULT 5x5 then yields 25 after 33 cycles.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide sequencer for the execute stage.
// Multiply: radix-2 Booth, one step per cycle. Divide: restoring on magnitudes.
// Optional macro MULTDIV_EARLY_OUT_EN: zero operands finish in one cycle.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned PROD_W = 2 * WIDTH + 1;

`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateType;

  stateType          state;
  logic [CNT_W-1:0]  counter;
  logic [PROD_W-1:0] prodReg;   // {high half, multiplier, Booth q(-1)}
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic [WIDTH-1:0]  remReg;
  logic [WIDTH-1:0]  quoReg;    // dividend magnitude shifts out as quotient shifts in

  logic [WIDTH:0]     hiExt;
  logic [WIDTH:0]     boothSum;
  logic [PROD_W-1:0]  boothNext;
  logic [2*WIDTH-1:0] product;
  logic               mulOvf;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH-1:0]   absInA;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divTrial;
  logic               qBit;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quoNext;
  logic [WIDTH-1:0]   quoSigned;
  logic               divByZero;
  logic               divOvf;
  logic               lastStep;
  logic               zeroOp;

  // Datapath for one Booth step and one restoring-division step
  always_comb begin
    // High half is widened by one bit so subtracting the most negative
    // multiplicand cannot wrap before the arithmetic shift.
    hiExt = {prodReg[PROD_W-1], prodReg[PROD_W-1:WIDTH+1]};
    case (prodReg[1:0])
      2'b01:   boothSum = hiExt + {opA[WIDTH-1], opA};
      2'b10:   boothSum = hiExt - {opA[WIDTH-1], opA};
      default: boothSum = hiExt;
    endcase
    boothNext = {boothSum, prodReg[WIDTH:1]};
    product   = boothNext[PROD_W-1:1];
    mulOvf    = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

    absB     = opB[WIDTH-1] ? (~opB + WIDTH'(1)) : opB;
    absInA   = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    divShift = {remReg, quoReg[WIDTH-1]};
    divTrial = divShift - {1'b0, absB};
    qBit     = !divTrial[WIDTH];
    remNext  = qBit ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
    quoNext  = {quoReg[WIDTH-2:0], qBit};
    quoSigned = (opA[WIDTH-1] ^ opB[WIDTH-1]) ? (~quoNext + WIDTH'(1)) : quoNext;

    divByZero = (opB == '0);
    divOvf    = (opA == {1'b1, {(WIDTH-1){1'b0}}}) && (&opB);
    lastStep  = (counter == CNT_W'(WIDTH - 1));
    zeroOp    = (data_operandA == '0) || (data_operandB == '0);
  end

  // Sequencer state, operand capture and registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      prodReg        <= '0;
      opA            <= '0;
      opB            <= '0;
      remReg         <= '0;
      quoReg         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (ctrl_MULT || ctrl_DIV) begin
            opA     <= data_operandA;
            opB     <= data_operandB;
            prodReg <= {WIDTH'(0), data_operandB, 1'b0};
            remReg  <= '0;
            quoReg  <= absInA;
            if (EARLY_OUT && zeroOp) begin
              state          <= DONE;
              data_result    <= '0;
              data_exception <= !ctrl_MULT && (data_operandB == '0);
              data_resultRDY <= 1'b1;
            end else begin
              state <= ctrl_MULT ? MULT : DIV;
              busy  <= 1'b1;
            end
          end
        end
        MULT: begin
          prodReg <= boothNext;
          counter <= counter + CNT_W'(1);
          if (lastStep) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= product[WIDTH-1:0];
            data_exception <= mulOvf;
          end
        end
        DIV: begin
          remReg  <= remNext;
          quoReg  <= quoNext;
          counter <= counter + CNT_W'(1);
          if (lastStep) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_exception <= divByZero || divOvf;
            if (divByZero)   data_result <= '0;
            else if (divOvf) data_result <= {1'b1, {(WIDTH-1){1'b0}}};
            else             data_result <= quoSigned;
          end
        end
        DONE: begin
          state   <= IDLE;
          counter <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: arithmetic reference model plus
// a per-cycle compare of busy/resultRDY timing and held result values.
module tb_multdiv_unit;

  localparam int unsigned W = 32;

`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [W-1:0] res;
  logic         exc;
  logic         rdy;
  logic         busy;

  multdiv_unit #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  int tests = 0;
  int fails = 0;

  // Expected-operation state shared between stimulus and compare process
  bit           chkEn = 1'b0;
  bit           pendActive = 1'b0;
  bit           pendEarly = 1'b0;
  int           pendStart = 0;
  logic [W-1:0] pendRes = '0;
  bit           pendExc = 1'b0;
  logic [W-1:0] holdRes = '0;
  bit           holdExc = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers
  function automatic void model(input bit isMul, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output bit e);
    longint     p;
    logic [63:0] pv;
    if (isMul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      r  = pv[31:0];
      e  = (p != longint'($signed(pv[31:0])));
    end else if (b == '0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = W'($signed(a) / $signed(b));
      e = 1'b0;
    end
  endfunction

  // Per-cycle compare of timing and held outputs against the expectation
  always @(negedge clk) begin
    int n;
    bit expBusy;
    bit expRdy;
    if (chkEn) begin
      n       = edgeCnt;
      expBusy = pendActive && !pendEarly && (n >= pendStart) && (n < pendStart + int'(W));
      expRdy  = pendActive && (n == pendStart + (pendEarly ? 0 : int'(W)));
      chk("busy", W'(busy), W'(expBusy));
      chk("resultRDY", W'(rdy), W'(expRdy));
      if (expRdy) begin
        holdRes    = pendRes;
        holdExc    = pendExc;
        pendActive = 1'b0;
      end
      chk("data_result", res, holdRes);
      chk("data_exception", W'(exc), W'(holdExc));
    end
  end

  task automatic startOp(input bit isMul, input bit isDiv, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    bit           e;
    int           s;
    @(negedge clk);
    ctrl_MULT = isMul;
    ctrl_DIV  = isDiv;
    opA = a;
    opB = b;
    s = edgeCnt + 1;
    model(isMul, a, b, r, e);
    @(posedge clk);
    pendStart  = s;
    pendRes    = r;
    pendExc    = e;
    pendEarly  = EARLY && (a == '0 || b == '0);
    pendActive = 1'b1;
    @(negedge clk);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic finishOp(input string name, input logic [W-1:0] litRes, input bit litExc);
    int budget = 100;
    while (pendActive && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (pendActive) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for completion", name);
      pendActive = 1'b0;
    end
    #1;
    chk({name, " result"}, res, litRes);
    chk({name, " exception"}, W'(exc), W'(litExc));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chkEn = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    startOp(1, 0, 32'd7, 32'hFFFF_FFFD);
    finishOp("mul 7*-3", 32'hFFFF_FFEB, 1'b0);
    startOp(1, 0, 32'h4000_0000, 32'd4);
    finishOp("mul ovf", 32'h0000_0000, 1'b1);
    startOp(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finishOp("mul -1*-1", 32'd1, 1'b0);
    startOp(1, 0, 32'h8000_0000, 32'h8000_0000);
    finishOp("mul min*min", 32'h0000_0000, 1'b1);
    startOp(1, 0, 32'd0, 32'd5);
    finishOp("mul 0*5", 32'd0, 1'b0);

    startOp(0, 1, 32'hFFFF_FFF9, 32'd2);
    finishOp("div -7/2", 32'hFFFF_FFFD, 1'b0);
    startOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    finishOp("div ovf", 32'h8000_0000, 1'b1);
    startOp(0, 1, 32'd100, 32'd0);
    finishOp("div by 0", 32'd0, 1'b1);
    startOp(0, 1, 32'h8000_0000, 32'd1);
    finishOp("div min/1", 32'h8000_0000, 1'b0);
    startOp(0, 1, 32'd7, 32'hFFFF_FFF9);
    finishOp("div 7/-7", 32'hFFFF_FFFF, 1'b0);
    startOp(0, 1, 32'd5, 32'd7);
    finishOp("div 5/7", 32'd0, 1'b0);
    startOp(0, 1, 32'd0, 32'd9);
    finishOp("div 0/9", 32'd0, 1'b0);

    startOp(1, 1, 32'd6, 32'd3);
    finishOp("mult wins", 32'd18, 1'b0);

    startOp(1, 0, 32'd100, 32'hFFFF_FFFD);
    repeat (5) @(negedge clk);
    ctrl_DIV = 1'b1;
    opA = 32'd50;
    opB = 32'd2;
    @(negedge clk);
    ctrl_DIV = 1'b0;
    finishOp("div ignored while busy", 32'hFFFF_FED4, 1'b0);
    repeat (5) @(posedge clk);

    startOp(0, 1, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    pendActive = 1'b0;
    holdRes    = '0;
    holdExc    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);

    startOp(1, 0, 32'd5, 32'd5);
    finishOp("mul after reset", 32'd25, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
